// File: rtl/wb_port_arbiter_if.sv
// Write-back port bundle: pipeline and long-latency sources in, register-file write port out.
interface wb_port_arbiter_if #(
    parameter int size  = 32,
    parameter int DEPTH = 2
);
    logic                         wb_we_i;
    logic [4:0]                   wb_addr_i;
    logic [size-1:0]              wb_data_i;
    logic                         lu_valid_i;
    logic [4:0]                   lu_addr_i;
    logic [size-1:0]              lu_data_i;
    logic                         lu_ready_o;
    logic                         stall_o;
    logic                         rf_we_o;
    logic [4:0]                   rf_addr_o;
    logic [size-1:0]              rf_data_o;
    logic [$clog2(DEPTH+1)-1:0]   pending_o;

    modport master (
        output wb_we_i, wb_addr_i, wb_data_i, lu_valid_i, lu_addr_i, lu_data_i,
        input  lu_ready_o, stall_o, rf_we_o, rf_addr_o, rf_data_o, pending_o
    );

    modport slave (
        input  wb_we_i, wb_addr_i, wb_data_i, lu_valid_i, lu_addr_i, lu_data_i,
        output lu_ready_o, stall_o, rf_we_o, rf_addr_o, rf_data_o, pending_o
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writes win, long-latency results wait in a
// small FIFO, and a starvation timer forces a one-cycle pipeline stall to drain the head.
module wb_port_arbiter #(
    parameter int size         = 32,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 8
) (
    input logic              clk,
    input logic              reset,
    wb_port_arbiter_if.slave bus
);
    // state  | meaning
    // NORMAL | pipeline has priority, FIFO head fills idle slots
    // FORCE  | pipeline stalled for one cycle, FIFO head owns the write port
    typedef enum logic {NORMAL = 1'b0, FORCE = 1'b1} state_t;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ST_W  = $clog2(STARVE_LIMIT + 1);

    state_t           state;
    state_t           state_next;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [ST_W-1:0]  starve_cnt;
    logic [4:0]       addr_mem [DEPTH];
    logic [size-1:0]  data_mem [DEPTH];

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic grant_wb;
    logic grant_lu;
    logic stall;
    logic starve_hit;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    assign bus.lu_ready_o = !full;
    assign bus.pending_o  = count;
    assign bus.stall_o    = stall;

    // Results destined for x0 are acknowledged but never stored.
    assign push = bus.lu_valid_i && !full && (bus.lu_addr_i != 5'd0);
    assign pop  = grant_lu;

    assign starve_hit = (state == NORMAL) && !empty && !grant_lu &&
                        (starve_cnt == ST_W'(STARVE_LIMIT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= NORMAL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            NORMAL:  if (starve_hit) state_next = FORCE;
            FORCE:   state_next = NORMAL;
            default: state_next = NORMAL;
        endcase
    end

    always_comb begin
        stall    = 1'b0;
        grant_wb = 1'b0;
        grant_lu = 1'b0;
        case (state)
            NORMAL: begin
                if (bus.wb_we_i && (bus.wb_addr_i != 5'd0)) begin
                    grant_wb = 1'b1;
                end else if (!empty) begin
                    grant_lu = 1'b1;
                end
            end
            FORCE: begin
                stall    = 1'b1;
                grant_lu = !empty;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= bus.lu_addr_i;
            data_mem[wr_ptr] <= bus.lu_data_i;
        end
    end

    // Cleared on entry to FORCE, so the head always gets a fresh window afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if ((state != NORMAL) || empty || grant_lu || starve_hit) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_cnt + ST_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.rf_we_o   <= 1'b0;
            bus.rf_addr_o <= '0;
            bus.rf_data_o <= '0;
        end else begin
            bus.rf_we_o <= grant_wb || grant_lu;
            if (grant_wb) begin
                bus.rf_addr_o <= bus.wb_addr_i;
                bus.rf_data_o <= bus.wb_data_i;
            end else if (grant_lu) begin
                bus.rf_addr_o <= addr_mem[rd_ptr];
                bus.rf_data_o <= data_mem[rd_ptr];
            end
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (DEPTH=2, STARVE_LIMIT=8).
module tb_wb_port_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    wb_port_arbiter_if #(.size(32), .DEPTH(2)) bus ();

    wb_port_arbiter #(.size(32), .DEPTH(2), .STARVE_LIMIT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.wb_we_i    = 1'b0;
        bus.wb_addr_i  = 5'd0;
        bus.wb_data_i  = 32'd0;
        bus.lu_valid_i = 1'b0;
        bus.lu_addr_i  = 5'd0;
        bus.lu_data_i  = 32'd0;
    endtask

    task automatic drive_wb(input logic [4:0] a, input logic [31:0] d);
        bus.wb_we_i   = 1'b1;
        bus.wb_addr_i = a;
        bus.wb_data_i = d;
    endtask

    task automatic drive_lu(input logic [4:0] a, input logic [31:0] d);
        bus.lu_valid_i = 1'b1;
        bus.lu_addr_i  = a;
        bus.lu_data_i  = d;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive_idle();
        #1 reset = 1'b1;
        #2;
        checks++;
        if ({bus.rf_we_o, bus.rf_addr_o, bus.rf_data_o} !== 38'd0) begin
            failures++;
            $display("FAIL reset_rf got we=%0b addr=%0d data=%h exp all zero", bus.rf_we_o, bus.rf_addr_o, bus.rf_data_o);
        end
        checks++;
        if (bus.stall_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_stall got=%0b exp=0", bus.stall_o);
        end
        checks++;
        if (bus.pending_o !== 2'd0) begin
            failures++;
            $display("FAIL reset_pending got=%0d exp=0", bus.pending_o);
        end
        checks++;
        if (bus.lu_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%0b exp=1", bus.lu_ready_o);
        end
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_pipeline_write();
        drive_wb(5'd5, 32'hDEADBEEF);
        tick();
        checks++;
        if ({bus.rf_we_o, bus.rf_addr_o, bus.rf_data_o} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL pipe_write got we=%0b addr=%0d data=%h exp we=1 addr=5 data=deadbeef", bus.rf_we_o, bus.rf_addr_o, bus.rf_data_o);
        end
        checks++;
        if (bus.stall_o !== 1'b0) begin
            failures++;
            $display("FAIL pipe_stall got=%0b exp=0", bus.stall_o);
        end
        drive_idle();
        tick();
        checks++;
        if ({bus.rf_we_o, bus.rf_addr_o, bus.rf_data_o} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL pipe_hold got we=%0b addr=%0d data=%h exp we=0 addr=5 data=deadbeef", bus.rf_we_o, bus.rf_addr_o, bus.rf_data_o);
        end
    endtask

    task automatic test_single_lu();
        drive_lu(5'd7, 32'h1234);
        tick();
        bus.lu_valid_i = 1'b0;
        checks++;
        if (bus.pending_o !== 2'd1 || bus.rf_we_o !== 1'b0) begin
            failures++;
            $display("FAIL lu_pending got pending=%0d we=%0b exp pending=1 we=0", bus.pending_o, bus.rf_we_o);
        end
        tick();
        checks++;
        if ({bus.rf_we_o, bus.rf_addr_o, bus.rf_data_o} !== {1'b1, 5'd7, 32'h1234}) begin
            failures++;
            $display("FAIL lu_write got we=%0b addr=%0d data=%h exp we=1 addr=7 data=00001234", bus.rf_we_o, bus.rf_addr_o, bus.rf_data_o);
        end
        checks++;
        if (bus.pending_o !== 2'd0) begin
            failures++;
            $display("FAIL lu_drained got=%0d exp=0", bus.pending_o);
        end
        tick();
        checks++;
        if (bus.rf_we_o !== 1'b0) begin
            failures++;
            $display("FAIL lu_idle got we=%0b exp=0", bus.rf_we_o);
        end
    endtask

    task automatic test_full();
        drive_wb(5'd1, 32'hA0);
        drive_lu(5'd2, 32'h22);
        tick();
        checks++;
        if (bus.pending_o !== 2'd1 || bus.lu_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL full_first got pending=%0d ready=%0b exp pending=1 ready=1", bus.pending_o, bus.lu_ready_o);
        end
        drive_wb(5'd1, 32'hA1);
        drive_lu(5'd3, 32'h33);
        tick();
        checks++;
        if (bus.pending_o !== 2'd2 || bus.lu_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL full_second got pending=%0d ready=%0b exp pending=2 ready=0", bus.pending_o, bus.lu_ready_o);
        end
        drive_wb(5'd1, 32'hA2);
        drive_lu(5'd4, 32'h44);
        tick();
        checks++;
        if (bus.pending_o !== 2'd2 || bus.lu_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL full_held got pending=%0d ready=%0b exp pending=2 ready=0", bus.pending_o, bus.lu_ready_o);
        end
        checks++;
        if ({bus.rf_we_o, bus.rf_addr_o, bus.rf_data_o} !== {1'b1, 5'd1, 32'hA2}) begin
            failures++;
            $display("FAIL full_pipe got we=%0b addr=%0d data=%h exp we=1 addr=1 data=000000a2", bus.rf_we_o, bus.rf_addr_o, bus.rf_data_o);
        end
        // Pipeline goes quiet; the third result is still offered and must wait for space.
        bus.wb_we_i = 1'b0;
        tick();
        checks++;
        if ({bus.rf_we_o, bus.rf_addr_o, bus.rf_data_o} !== {1'b1, 5'd2, 32'h22} || bus.pending_o !== 2'd1) begin
            failures++;
            $display("FAIL full_pop1 got we=%0b addr=%0d data=%h pending=%0d exp we=1 addr=2 data=00000022 pending=1", bus.rf_we_o, bus.rf_addr_o, bus.rf_data_o, bus.pending_o);
        end
        tick();
        checks++;
        if ({bus.rf_we_o, bus.rf_addr_o, bus.rf_data_o} !== {1'b1, 5'd3, 32'h33} || bus.pending_o !== 2'd1) begin
            failures++;
            $display("FAIL full_pop2 got we=%0b addr=%0d data=%h pending=%0d exp we=1 addr=3 data=00000033 pending=1", bus.rf_we_o, bus.rf_addr_o, bus.rf_data_o, bus.pending_o);
        end
        bus.lu_valid_i = 1'b0;
        tick();
        checks++;
        if ({bus.rf_we_o, bus.rf_addr_o, bus.rf_data_o} !== {1'b1, 5'd4, 32'h44} || bus.pending_o !== 2'd0) begin
            failures++;
            $display("FAIL full_pop3 got we=%0b addr=%0d data=%h pending=%0d exp we=1 addr=4 data=00000044 pending=0", bus.rf_we_o, bus.rf_addr_o, bus.rf_data_o, bus.pending_o);
        end
        drive_idle();
    endtask

    task automatic test_push_pop_wrap();
        logic        exp_we;
        logic [4:0]  exp_a;
        logic [31:0] exp_d;
        exp_we = 1'b0;
        exp_a  = 5'd4;
        exp_d  = 32'h44;
        for (int i = 0; i < 4; i++) begin
            drive_lu(5'(12 + i), 32'h5000 + 32'(i));
            tick();
            checks++;
            if (bus.pending_o !== 2'd1) begin
                failures++;
                $display("FAIL wrap_pending step=%0d got=%0d exp=1", i, bus.pending_o);
            end
            checks++;
            if ({bus.rf_we_o, bus.rf_addr_o, bus.rf_data_o} !== {exp_we, exp_a, exp_d}) begin
                failures++;
                $display("FAIL wrap_order step=%0d got we=%0b addr=%0d data=%h exp we=%0b addr=%0d data=%h", i, bus.rf_we_o, bus.rf_addr_o, bus.rf_data_o, exp_we, exp_a, exp_d);
            end
            exp_we = 1'b1;
            exp_a  = 5'(12 + i);
            exp_d  = 32'h5000 + 32'(i);
        end
        bus.lu_valid_i = 1'b0;
        tick();
        checks++;
        if ({bus.rf_we_o, bus.rf_addr_o, bus.rf_data_o, bus.pending_o} !== {1'b1, 5'd15, 32'h5003, 2'd0}) begin
            failures++;
            $display("FAIL wrap_last got we=%0b addr=%0d data=%h pending=%0d exp we=1 addr=15 data=00005003 pending=0", bus.rf_we_o, bus.rf_addr_o, bus.rf_data_o, bus.pending_o);
        end
        drive_idle();
    endtask

    task automatic test_starvation();
        logic exp_stall;
        drive_wb(5'd1, 32'h100);
        drive_lu(5'd9, 32'h99);
        tick();
        bus.lu_valid_i = 1'b0;
        checks++;
        if (bus.pending_o !== 2'd1 || bus.stall_o !== 1'b0) begin
            failures++;
            $display("FAIL starve_push got pending=%0d stall=%0b exp pending=1 stall=0", bus.pending_o, bus.stall_o);
        end
        // Head waits from here; the counter reaches 7 in the eighth blocked cycle.
        for (int i = 0; i < 8; i++) begin
            drive_wb(5'd1, 32'h200 + 32'(i));
            tick();
            exp_stall = (i == 7);
            checks++;
            if (bus.stall_o !== exp_stall) begin
                failures++;
                $display("FAIL starve_stall step=%0d got=%0b exp=%0b", i, bus.stall_o, exp_stall);
            end
            checks++;
            if ({bus.rf_we_o, bus.rf_addr_o, bus.rf_data_o} !== {1'b1, 5'd1, 32'h200 + 32'(i)}) begin
                failures++;
                $display("FAIL starve_pipe step=%0d got we=%0b addr=%0d data=%h exp we=1 addr=1 data=%h", i, bus.rf_we_o, bus.rf_addr_o, bus.rf_data_o, 32'h200 + 32'(i));
            end
        end
        drive_wb(5'd1, 32'h208);
        tick();
        checks++;
        if ({bus.rf_we_o, bus.rf_addr_o, bus.rf_data_o} !== {1'b1, 5'd9, 32'h99} || bus.stall_o !== 1'b0 || bus.pending_o !== 2'd0) begin
            failures++;
            $display("FAIL starve_forced got we=%0b addr=%0d data=%h stall=%0b pending=%0d exp we=1 addr=9 data=00000099 stall=0 pending=0", bus.rf_we_o, bus.rf_addr_o, bus.rf_data_o, bus.stall_o, bus.pending_o);
        end
        tick();
        checks++;
        if ({bus.rf_we_o, bus.rf_addr_o, bus.rf_data_o} !== {1'b1, 5'd1, 32'h208} || bus.stall_o !== 1'b0) begin
            failures++;
            $display("FAIL starve_held got we=%0b addr=%0d data=%h stall=%0b exp we=1 addr=1 data=00000208 stall=0", bus.rf_we_o, bus.rf_addr_o, bus.rf_data_o, bus.stall_o);
        end
        drive_idle();
        tick();
        checks++;
        if (bus.rf_we_o !== 1'b0) begin
            failures++;
            $display("FAIL starve_idle got we=%0b exp=0", bus.rf_we_o);
        end
    endtask

    task automatic test_x0();
        drive_wb(5'd0, 32'hFFFF);
        drive_lu(5'd0, 32'hEEEE);
        tick();
        checks++;
        if (bus.rf_we_o !== 1'b0 || bus.pending_o !== 2'd0 || bus.lu_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL x0_drop got we=%0b pending=%0d ready=%0b exp we=0 pending=0 ready=1", bus.rf_we_o, bus.pending_o, bus.lu_ready_o);
        end
        drive_lu(5'd6, 32'h66);
        tick();
        bus.lu_valid_i = 1'b0;
        checks++;
        if (bus.rf_we_o !== 1'b0 || bus.pending_o !== 2'd1) begin
            failures++;
            $display("FAIL x0_push got we=%0b pending=%0d exp we=0 pending=1", bus.rf_we_o, bus.pending_o);
        end
        tick();
        checks++;
        if ({bus.rf_we_o, bus.rf_addr_o, bus.rf_data_o, bus.pending_o} !== {1'b1, 5'd6, 32'h66, 2'd0}) begin
            failures++;
            $display("FAIL x0_idle_slot got we=%0b addr=%0d data=%h pending=%0d exp we=1 addr=6 data=00000066 pending=0", bus.rf_we_o, bus.rf_addr_o, bus.rf_data_o, bus.pending_o);
        end
        drive_idle();
    endtask

    task automatic test_reset_mid();
        drive_wb(5'd1, 32'h300);
        drive_lu(5'd10, 32'hAA);
        tick();
        drive_wb(5'd1, 32'h301);
        drive_lu(5'd11, 32'hBB);
        tick();
        bus.lu_valid_i = 1'b0;
        drive_wb(5'd1, 32'h302);
        checks++;
        if (bus.pending_o !== 2'd2) begin
            failures++;
            $display("FAIL rst_mid_fill got pending=%0d exp=2", bus.pending_o);
        end
        #3 reset = 1'b1;
        #1;
        checks++;
        if ({bus.rf_we_o, bus.rf_addr_o, bus.rf_data_o} !== 38'd0 || bus.stall_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_rf got we=%0b addr=%0d data=%h stall=%0b exp all zero", bus.rf_we_o, bus.rf_addr_o, bus.rf_data_o, bus.stall_o);
        end
        checks++;
        if (bus.pending_o !== 2'd0 || bus.lu_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_fifo got pending=%0d ready=%0b exp pending=0 ready=1", bus.pending_o, bus.lu_ready_o);
        end
        drive_idle();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus.rf_we_o !== 1'b0 || bus.pending_o !== 2'd0) begin
                failures++;
                $display("FAIL rst_mid_flushed step=%0d got we=%0b pending=%0d exp we=0 pending=0", i, bus.rf_we_o, bus.pending_o);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_pipeline_write();
        test_single_lu();
        test_full();
        test_push_pop_wrap();
        test_starvation();
        test_x0();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
